mac_layer_scheduler: RTL and testbench

MAC_LAYER_SCHEDULER -- requirements
Module: mac_layer_scheduler

---
 rtl/mac_layer_scheduler.sv | 174 +++++++++++++++++
 tb/tb_mac_layer_scheduler.sv | 205 ++++++++++++++++++++
 2 files changed

// File: rtl/mac_layer_scheduler.sv
// Sequences one fully-connected layer through a pipelined chunk MAC.
// Ports: clk/rst, start/busy/done, x/w/b memory reads, mac_* issue/return, y_* neuron outputs.
module mac_layer_scheduler #(
   parameter int CHUNKS = 4,
   parameter int N_OUT  = 16,
   localparam int CW = (CHUNKS > 1) ? $clog2(CHUNKS) : 1,
   localparam int NW = (N_OUT > 1) ? $clog2(N_OUT) : 1,
   localparam int WW = (N_OUT * CHUNKS > 1) ? $clog2(N_OUT * CHUNKS) : 1
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          start,
   output logic          busy,
   output logic          done,
   output logic [CW-1:0] x_addr,
   input  logic [511:0]  x_data,
   output logic [WW-1:0] w_addr,
   input  logic [511:0]  w_data,
   output logic [NW-1:0] b_addr,
   input  logic [15:0]   b_data,
   output logic          mac_start,
   output logic [511:0]  mac_a,
   output logic [511:0]  mac_b,
   output logic [15:0]   mac_bias,
   input  logic [15:0]   mac_result,
   input  logic          mac_done,
   output logic          y_valid,
   output logic [NW-1:0] y_idx,
   output logic [15:0]   y_data
);

   typedef enum logic [1:0] {
      S_IDLE,
      S_ISSUE,
      S_DRAIN,
      S_FIN
   } state_t;

   localparam int TOTAL = N_OUT * CHUNKS;
   localparam logic [WW-1:0] ISS_LAST = WW'(TOTAL - 1);
   localparam logic [CW-1:0] CH_LAST  = CW'(CHUNKS - 1);
   localparam logic [NW-1:0] N_LAST   = NW'(N_OUT - 1);
   localparam logic [WW:0]   RET_ALL  = (WW + 1)'(TOTAL);

   state_t state_q, state_d;

   logic [CW-1:0]      ich_q;
   logic [WW-1:0]      icnt_q;
   logic [CW-1:0]      rch_q;
   logic [NW-1:0]      rn_q;
   logic [WW:0]        rcnt_q;
   logic signed [19:0] acc_q;
   logic               mac_start_q;
   logic               y_valid_q;
   logic [NW-1:0]      y_idx_q;
   logic [15:0]        y_data_q;

   logic               issue;
   logic               iss_last;
   logic               ret_ok;
   logic               ret_fin;
   logic signed [19:0] res_x;
   logic signed [19:0] sum;
   logic [15:0]        sat;

   assign issue    = (state_q == S_ISSUE);
   assign iss_last = issue && (icnt_q == ISS_LAST);

   // Returns only count while a layer is live and not yet complete,
   // so stale results after an aborted layer fall on the floor.
   assign ret_ok  = mac_done && (state_q == S_ISSUE || state_q == S_DRAIN)
                    && (rcnt_q != RET_ALL);
   assign ret_fin = ret_ok && (rch_q == CH_LAST);

   assign res_x = {{4{mac_result[15]}}, mac_result};
   assign sum   = acc_q + res_x + {{4{b_data[15]}}, b_data};

   always_comb begin
      sat = sum[15:0];
      if (sum > 20'sd32767)
         sat = 16'h7FFF;
      else if (sum < -20'sd32768)
         sat = 16'h8000;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         state_q <= S_IDLE;
      else
         state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      busy    = 1'b1;
      done    = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            busy = 1'b0;
            if (start)
               state_d = S_ISSUE;
         end
         S_ISSUE: begin
            if (iss_last)
               state_d = S_DRAIN;
         end
         S_DRAIN: begin
            // Last y_valid goes out on the same edge that completes the count.
            if (rcnt_q == RET_ALL && y_valid_q)
               state_d = S_FIN;
         end
         S_FIN: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ich_q       <= '0;
         icnt_q      <= '0;
         rch_q       <= '0;
         rn_q        <= '0;
         rcnt_q      <= '0;
         acc_q       <= '0;
         mac_start_q <= 1'b0;
         y_valid_q   <= 1'b0;
         y_idx_q     <= '0;
         y_data_q    <= '0;
      end else begin
         mac_start_q <= issue;
         y_valid_q   <= 1'b0;
         if (state_q == S_IDLE && start) begin
            ich_q  <= '0;
            icnt_q <= '0;
            rch_q  <= '0;
            rn_q   <= '0;
            rcnt_q <= '0;
            acc_q  <= '0;
         end
         if (issue) begin
            icnt_q <= iss_last ? '0 : icnt_q + 1'b1;
            ich_q  <= (ich_q == CH_LAST) ? '0 : ich_q + 1'b1;
         end
         if (ret_ok) begin
            rcnt_q <= rcnt_q + 1'b1;
            if (ret_fin) begin
               rch_q     <= '0;
               rn_q      <= (rn_q == N_LAST) ? '0 : rn_q + 1'b1;
               acc_q     <= '0;
               y_valid_q <= 1'b1;
               y_idx_q   <= rn_q;
               y_data_q  <= sat;
            end else begin
               rch_q <= rch_q + 1'b1;
               acc_q <= acc_q + res_x;
            end
         end
      end
   end

   assign x_addr    = ich_q;
   assign w_addr    = icnt_q;
   assign b_addr    = rn_q;
   assign mac_start = mac_start_q;
   assign mac_a     = x_data;
   assign mac_b     = w_data;
   assign mac_bias  = 16'h0000;
   assign y_valid   = y_valid_q;
   assign y_idx     = y_idx_q;
   assign y_data    = y_data_q;

endmodule

// File: tb/tb_mac_layer_scheduler.sv
// Directed bench for mac_layer_scheduler with CHUNKS=4, N_OUT=2.
// Registered x/w/b memories and an 8-cycle pipelined MAC model.
module tb_mac_layer_scheduler;

   localparam int C = 4;
   localparam int N = 2;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         start = 1'b0;
   logic         busy, done;
   logic [1:0]   x_addr;
   logic [2:0]   w_addr;
   logic [0:0]   b_addr;
   logic [511:0] x_data = '0;
   logic [511:0] w_data = '0;
   logic [15:0]  b_data = '0;
   logic         mac_start;
   logic [511:0] mac_a, mac_b;
   logic [15:0]  mac_bias;
   logic [15:0]  mac_result;
   logic         mac_done;
   logic         y_valid;
   logic [0:0]   y_idx;
   logic [15:0]  y_data;

   mac_layer_scheduler #(.CHUNKS(C), .N_OUT(N)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .x_addr(x_addr), .x_data(x_data),
      .w_addr(w_addr), .w_data(w_data),
      .b_addr(b_addr), .b_data(b_data),
      .mac_start(mac_start), .mac_a(mac_a), .mac_b(mac_b),
      .mac_bias(mac_bias), .mac_result(mac_result), .mac_done(mac_done),
      .y_valid(y_valid), .y_idx(y_idx), .y_data(y_data)
   );

   always #5 clk = ~clk;

   logic [15:0] xm [C];
   logic [15:0] wm [N*C];
   logic [15:0] bm [N];

   always @(posedge clk) begin
      x_data <= {32{xm[x_addr]}};
      w_data <= {32{wm[w_addr]}};
      b_data <= bm[b_addr];
   end

   function automatic logic [15:0] dot(input logic [511:0] a,
                                       input logic [511:0] b);
      longint s;
      s = 0;
      for (int e = 0; e < 32; e++)
         s += longint'($signed(a[e*16 +: 16])) *
              longint'($signed(b[e*16 +: 16]));
      return 16'(s >>> 8);
   endfunction

   logic [7:0]  pv = '0;
   logic [15:0] pr [8];

   always @(posedge clk) begin
      pv    <= {pv[6:0], mac_start};
      pr[0] <= dot(mac_a, mac_b);
      for (int i = 1; i < 8; i++)
         pr[i] <= pr[i-1];
   end

   assign mac_done   = pv[7];
   assign mac_result = pr[7];

   int n_cmp = 0;
   int n_bad = 0;

   task automatic chk(input string tag, input logic [31:0] got,
                      input logic [31:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got %0h want %0h", tag, got, exp);
      end
   endtask

   int yi[$], yd[$], yc[$];
   int nd, dc, nms, ms_first, ms_last;

   task automatic run(input int ncyc, input bit do_st,
                      input int p0, input int p1, input int rst_at);
      yi.delete(); yd.delete(); yc.delete();
      nd = 0; dc = -1; nms = 0; ms_first = -1; ms_last = -1;
      @(negedge clk);
      start = do_st;
      for (int c = 1; c <= ncyc; c++) begin
         @(negedge clk);
         if (y_valid) begin
            yi.push_back(int'(y_idx));
            yd.push_back(int'(y_data));
            yc.push_back(c);
         end
         if (done) begin
            nd++;
            dc = c;
         end
         if (mac_start) begin
            nms++;
            if (ms_first < 0) ms_first = c;
            ms_last = c;
         end
         start = (c == p0 || c == p1);
         if (c == rst_at + 1) rst = 1'b0;
         if (c == rst_at) begin
            rst = 1'b1;
            #1;
            chk("rst_busy", busy, 0);
            chk("rst_done", done, 0);
            chk("rst_mstart", mac_start, 0);
            chk("rst_yvalid", y_valid, 0);
            chk("rst_xaddr", x_addr, 0);
            chk("rst_waddr", w_addr, 0);
         end
      end
      start = 1'b0;
   endtask

   function automatic int at(input int q[$], input int k);
      return (q.size() > k) ? q[k] : -1;
   endfunction

   task automatic check_layer(input string t, input int e0, input int e1);
      chk({t, "_ny"}, yd.size(), 2);
      chk({t, "_idx0"}, at(yi, 0), 0);
      chk({t, "_idx1"}, at(yi, 1), 1);
      chk({t, "_y0"}, at(yd, 0), e0);
      chk({t, "_y1"}, at(yd, 1), e1);
      chk({t, "_cyc0"}, at(yc, 0), 14);
      chk({t, "_cyc1"}, at(yc, 1), 18);
      chk({t, "_ndone"}, nd, 1);
      chk({t, "_donecyc"}, dc, 19);
      chk({t, "_nms"}, nms, 8);
      chk({t, "_ms_first"}, ms_first, 2);
      chk({t, "_ms_last"}, ms_last, 9);
   endtask

   task automatic setup(input logic [15:0] xv, input logic [15:0] wv,
                        input logic [15:0] b0, input logic [15:0] b1);
      for (int k = 0; k < C; k++) xm[k] = xv;
      for (int k = 0; k < N*C; k++) wm[k] = wv;
      bm[0] = b0;
      bm[1] = b1;
   endtask

   initial begin
      setup(16'h0000, 16'h0000, 16'h0000, 16'h0000);
      repeat (2) @(negedge clk);
      chk("reset_busy", busy, 0);
      chk("reset_done", done, 0);
      chk("reset_mstart", mac_start, 0);
      chk("reset_yvalid", y_valid, 0);
      chk("reset_ydata", y_data, 0);
      chk("reset_yidx", y_idx, 0);
      chk("reset_baddr", b_addr, 0);
      chk("reset_mbias", mac_bias, 0);
      rst = 1'b0;
      @(negedge clk);
      chk("idle_busy", busy, 0);

      // 32 * 1.0 * 0.5 per chunk, 4 chunks -> 64.0
      setup(16'h0100, 16'h0080, 16'h0000, 16'h0000);
      run(25, 1'b1, -1, -1, -1);
      check_layer("basic", 32'h4000, 32'h4000);

      // chunk k carries (k+1).0, weights 1/16 and 1/8 per neuron
      setup(16'h0000, 16'h0010, 16'h0000, 16'h0000);
      for (int k = 0; k < C; k++) xm[k] = 16'((k + 1) * 256);
      for (int k = C; k < N*C; k++) wm[k] = 16'h0020;
      run(25, 1'b1, -1, -1, -1);
      check_layer("order", 32'h1400, 32'h2800);

      setup(16'h0100, 16'h0100, 16'h7F00, 16'h7F00);
      run(25, 1'b1, -1, -1, -1);
      check_layer("satpos", 32'h7FFF, 32'h7FFF);

      setup(16'h0100, 16'hFF00, 16'h8100, 16'h8100);
      run(25, 1'b1, -1, -1, -1);
      check_layer("satneg", 32'h8000, 32'h8000);

      setup(16'h0000, 16'h0080, 16'h0000, 16'h0100);
      run(25, 1'b1, -1, -1, -1);
      check_layer("bias", 32'h0000, 32'h0100);

      setup(16'h0100, 16'h0080, 16'h0000, 16'h0000);
      run(40, 1'b1, 3, 12, -1);
      check_layer("restart", 32'h4000, 32'h4000);

      run(30, 1'b1, -1, -1, 6);
      chk("abort_ny", yd.size(), 0);
      chk("abort_ndone", nd, 0);
      run(25, 1'b1, -1, -1, -1);
      check_layer("after_rst", 32'h4000, 32'h4000);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
